// File: rtl/ssp_tx_arbiter.sv
// Round-robin arbiter sharing one SSP frame transmitter among NREQ byte requesters.
// Optional SSP_ARB_PRIORITY_EN gives requester 0 strict priority over the round-robin group.
module ssp_tx_arbiter #(
   parameter int NREQ          = 4,
   parameter int START_TIMEOUT = 15
) (
   input  logic              i_pclk,
   input  logic              i_clear,
   input  logic [NREQ-1:0]   i_req,
   input  logic [8*NREQ-1:0] i_req_data,
   output logic [NREQ-1:0]   o_ack,
   input  logic              i_transmit_complete,
   output logic              o_tx_ready,
   output logic [7:0]        o_tx_data,
   output logic [2:0]        o_grant_id,
   output logic              o_busy,
   output logic              o_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_START,
      S_WAIT_DONE
   } state_t;

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [2:0]      r_last;

   logic [NREQ-1:0] w_cand;
   logic [NREQ-1:0] w_onehot;
   logic            w_found;
   logic [2:0]      w_winner;
   logic [7:0]      w_byte;
   logic            w_rr_update;

   // Descending offset scan: the last hit is the nearest requester after r_last.
   always_comb begin
      w_cand      = i_req;
      w_onehot    = '0;
      w_found     = 1'b0;
      w_winner    = r_last;
      w_rr_update = 1'b1;
`ifdef SSP_ARB_PRIORITY_EN
      w_cand[0]   = 1'b0;
`endif
      for (int k = NREQ; k >= 1; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_cand[i] && (i == ((int'(r_last) + k) % NREQ))) begin
               w_found     = 1'b1;
               w_winner    = 3'(i);
               w_onehot    = '0;
               w_onehot[i] = 1'b1;
            end
         end
      end
`ifdef SSP_ARB_PRIORITY_EN
      // Requester 0 preempts the rotation and leaves r_last untouched.
      if (i_req[0]) begin
         w_found     = 1'b1;
         w_winner    = 3'd0;
         w_onehot    = '0;
         w_onehot[0] = 1'b1;
         w_rr_update = 1'b0;
      end
`endif
   end

   always_comb begin
      w_byte = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (w_onehot[i]) begin
            w_byte = i_req_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge i_pclk) begin
      if (i_clear) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_last     <= 3'(NREQ - 1);
         o_ack      <= '0;
         o_tx_ready <= 1'b0;
         o_tx_data  <= 8'h00;
         o_grant_id <= 3'd0;
         o_busy     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_ack <= '0;
         o_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found && i_transmit_complete) begin
                  o_tx_data  <= w_byte;
                  o_grant_id <= w_winner;
                  o_ack      <= w_onehot;
                  o_busy     <= 1'b1;
                  r_state    <= S_LOAD;
                  if (w_rr_update) begin
                     r_last <= w_winner;
                  end
               end
            end
            S_LOAD: begin
               o_tx_ready <= 1'b1;
               r_cnt      <= 4'd0;
               r_state    <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (!i_transmit_complete) begin
                  o_tx_ready <= 1'b0;
                  r_state    <= S_WAIT_DONE;
               end else if (r_cnt == 4'(START_TIMEOUT - 1)) begin
                  // Transmitter never started: the byte is dropped, not retried.
                  o_tx_ready <= 1'b0;
                  o_err      <= 1'b1;
                  o_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_WAIT_DONE: begin
               if (i_transmit_complete) begin
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               o_tx_ready <= 1'b0;
               o_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// Directed bench for ssp_tx_arbiter with a behavioural 8-bit SSP transmitter model.
module tb_ssp_tx_arbiter;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  ack;
   logic        tc = 1'b1;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic [2:0]  grant_id;
   logic        busy;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   logic       tie_high = 1'b0;
   logic [3:0] x_cnt = 4'd0;

   int         cyc = 0;
   int         ack_cnt = 0;
   int         err_cnt = 0;
   int         stab_err = 0;
   logic [7:0] held = 8'h00;
   int         ack_id_q[$];
   int         ack_dat_q[$];
   int         ack_cyc_q[$];

   ssp_tx_arbiter #(.NREQ(4), .START_TIMEOUT(15)) dut (
      .i_pclk              (clk),
      .i_clear             (clear),
      .i_req               (req),
      .i_req_data          (req_data),
      .o_ack               (ack),
      .i_transmit_complete (tc),
      .o_tx_ready          (tx_ready),
      .o_tx_data           (tx_data),
      .o_grant_id          (grant_id),
      .o_busy              (busy),
      .o_err               (err)
   );

   initial forever #5 clk = ~clk;

   // Transmitter: samples tx_ready while idle, then stays busy for 8 cycles after the start cycle.
   always @(posedge clk) begin
      if (tie_high) begin
         tc <= 1'b1;
      end else if (tc && tx_ready) begin
         tc    <= 1'b0;
         x_cnt <= 4'd8;
      end else if (!tc) begin
         if (x_cnt == 4'd0) tc <= 1'b1;
         else               x_cnt <= x_cnt - 4'd1;
      end
   end

   always begin
      @(posedge clk);
      #2;
      cyc++;
      if (ack != 4'b0000) begin
         ack_cnt++;
         ack_id_q.push_back(int'(grant_id));
         ack_dat_q.push_back(int'(tx_data));
         ack_cyc_q.push_back(cyc);
         held = tx_data;
      end else if (busy && tx_data !== held) begin
         stab_err++;
      end
      if (err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy || !tc) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 200), 32'd1);
   endtask

   task automatic do_reset();
      clear = 1'b1;
      step(2);
      clear = 1'b0;
   endtask

   initial begin
      int base;
      int a0;
      int e0;
      int n;
      logic [7:0] exp_dat[5];
      int         exp_id[5];

      // Reset values
      step(2);
      chk("rst_tx_ready", 32'(tx_ready), 32'd0);
      chk("rst_tx_data",  32'(tx_data),  32'h00);
      chk("rst_ack",      32'(ack),      32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_err",      32'(err),      32'd0);
      clear = 1'b0;

      // Single request from requester 1
      req_data = 32'h0000_A500;
      req = 4'b0010;
      step(1);
      chk("single_ack",      32'(ack),      32'b0010);
      chk("single_data",     32'(tx_data),  32'hA5);
      chk("single_gid",      32'(grant_id), 32'd1);
      chk("single_busy",     32'(busy),     32'd1);
      chk("single_rdy_n1",   32'(tx_ready), 32'd0);
      req = 4'b0000;
      step(1);
      chk("single_ack_pulse", 32'(ack),     32'd0);
      chk("single_rdy_n2",   32'(tx_ready), 32'd1);
      step(1);
      chk("single_rdy_n3",   32'(tx_ready), 32'd1);
      chk("single_tc_low",   32'(tc),       32'd0);
      step(1);
      chk("single_rdy_n4",   32'(tx_ready), 32'd0);
      step(8);
      chk("single_tc_back",  32'(tc),       32'd1);
      chk("single_busy_n12", 32'(busy),     32'd1);
      step(1);
      chk("single_busy_n13", 32'(busy),     32'd0);

      // Late deassert: req[1] dropped one cycle after its ack
      wait_idle("late_idle_pre");
      base = ack_cnt;
      req_data = 32'h0000_B700;
      req = 4'b0010;
      step(1);
      chk("late_ack", 32'(ack), 32'b0010);
      step(1);
      req = 4'b0000;
      step(12);
      chk("late_ack_count", 32'(ack_cnt - base), 32'd1);
      chk("late_data",      32'(tx_data),        32'hB7);
      chk("late_busy",      32'(busy),           32'd0);

      // Fairness with all four requesters held
      wait_idle("fair_idle_pre");
      do_reset();
      base = ack_id_q.size();
      req_data = 32'h1312_1110;
      req = 4'b1111;
`ifdef SSP_ARB_PRIORITY_EN
      exp_id  = '{0, 0, 0, 0, 0};
      exp_dat = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
      exp_id  = '{0, 1, 2, 3, 0};
      exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
      n = 0;
      while (ack_id_q.size() < base + 5 && n < 100) begin
         step(1);
         n++;
      end
      req = 4'b0000;
      chk("fair_timeout", 32'(n < 100), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (ack_id_q.size() > base + i) begin
            chk($sformatf("fair_id%0d", i),  32'(ack_id_q[base+i]),  32'(exp_id[i]));
            chk($sformatf("fair_dat%0d", i), 32'(ack_dat_q[base+i]), 32'(exp_dat[i]));
         end else begin
            chk($sformatf("fair_missing%0d", i), 32'd0, 32'd1);
         end
      end
      if (ack_cyc_q.size() > base + 1) begin
         chk("fair_spacing", 32'(ack_cyc_q[base+1] - ack_cyc_q[base]), 32'd13);
      end else begin
         chk("fair_spacing_missing", 32'd0, 32'd1);
      end
      wait_idle("fair_idle_post");
      chk("fair_stable", 32'(stab_err), 32'd0);

      // Start timeout with transmit_complete stuck high
      tie_high = 1'b1;
      do_reset();
      e0 = err_cnt;
      req_data = 32'h0000_00C3;
      req = 4'b0001;
      step(1);
      chk("to_ack", 32'(ack), 32'b0001);
      req = 4'b0000;
      step(15);
      chk("to_err_n16",  32'(err),      32'd0);
      chk("to_rdy_n16",  32'(tx_ready), 32'd1);
      step(1);
      chk("to_err_n17",  32'(err),      32'd1);
      chk("to_rdy_n17",  32'(tx_ready), 32'd0);
      chk("to_busy_n17", 32'(busy),     32'd0);
      step(1);
      chk("to_err_n18",  32'(err),      32'd0);
      step(4);
      chk("to_err_count", 32'(err_cnt - e0), 32'd1);
      tie_high = 1'b0;

      // Reset during WAIT_DONE while the transmitter is still busy
      step(2);
      wait_idle("rst_mid_idle_pre");
      req_data = 32'h00D4_0000;
      req = 4'b0100;
      step(1);
      chk("mid_ack", 32'(ack), 32'b0100);
      step(5);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("mid_tx_ready", 32'(tx_ready), 32'd0);
      chk("mid_tx_data",  32'(tx_data),  32'h00);
      chk("mid_ack_rst",  32'(ack),      32'd0);
      chk("mid_gid",      32'(grant_id), 32'd0);
      chk("mid_busy",     32'(busy),     32'd0);
      chk("mid_err",      32'(err),      32'd0);
      chk("mid_tc_low",   32'(tc),       32'd0);
      a0 = ack_cnt;
      step(5);
      chk("mid_no_ack",   32'(ack_cnt - a0), 32'd0);
      chk("mid_tc_back",  32'(tc),           32'd1);
      step(1);
      chk("mid_regrant",  32'(ack),      32'b0100);
      chk("mid_regrant_gid", 32'(grant_id), 32'd2);
      chk("mid_regrant_dat", 32'(tx_data),  32'hD4);
      req = 4'b0000;
      wait_idle("mid_idle_post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
